// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for a 16-bit word machine.
//
// Drives pc / next_pc into a unified word memory and receives the two words
// at those addresses combinationally. Each cycle it forms one candidate
// instruction entry: one word, or two words when fetch_instr[15] is set, with
// the second word as the immediate. Complete entries go into a small FIFO
// whose head is presented to decode through a valid/ready handshake.
//
// Handshake: an entry is transferred on a rising edge where out_valid and
// out_ready are both high. out_* stay stable while out_valid=1 and
// out_ready=0, and hold their last value while the queue is empty.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   fetch_en          allows fetching/pushing new instructions
//   pc, next_pc       fetch addresses (pc register and pc+1)
//   fetch_instr       memory word at pc
//   fetch_next_instr  memory word at next_pc
//   redirect          flush the queue and reload pc from redirect_pc
//   redirect_pc       new pc used when redirect=1
//   out_valid         queue head is valid
//   out_ready         decode accepts the head
//   out_instr         head instruction word
//   out_imm           head immediate (0 for one-word instructions)
//   out_len           0 = one word, 1 = two words
//   out_pc            address of the head instruction
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [15:0] pc,
  output logic [15:0] next_pc,
  input  logic [15:0] fetch_instr,
  input  logic [15:0] fetch_next_instr,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_imm,
  output logic        out_len,
  output logic [15:0] out_pc
);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic        len;
    logic [15:0] pc;
  } entry_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [15:0]   pc_q;
  entry_t        store [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  entry_t        head_q;

  logic          len;
  entry_t        new_entry;
  logic          pop;
  logic          push;
  logic [CW-1:0] remaining;
  logic [AW-1:0] head_idx;
  entry_t        head_next;
  logic          load_head;

  assign len       = fetch_instr[15];
  assign new_entry = '{instr: fetch_instr,
                       imm:   len ? fetch_next_instr : 16'h0000,
                       len:   len,
                       pc:    pc_q};

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A pop frees a slot in the same cycle, so a full queue still accepts a push.
  assign push      = fetch_en & ~redirect & ((count < DEPTH_C) | pop);

  // head_q is a registered copy of the queue head. Work out what the head
  // will be after this edge: the next stored entry if anything remains after
  // the pop, otherwise the entry being pushed right now (empty-queue bypass
  // into the register, giving one-cycle latency).
  always_comb begin
    remaining = count - CW'(pop);
    head_idx  = rd_ptr + AW'(pop);
    head_next = head_q;
    load_head = 1'b0;
    if (!redirect) begin
      if (remaining != '0) begin
        head_next = store[head_idx];
        load_head = 1'b1;
      end else if (push) begin
        head_next = new_entry;
        load_head = 1'b1;
      end
    end
  end

  // Queue storage carries no reset; count/pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else if (redirect) begin
      // Redirect wins: everything queued (including an entry popped this
      // cycle) is discarded and fetch restarts at redirect_pc.
      pc_q   <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q   <= pc_q + (len ? 16'd2 : 16'd1);
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (load_head) head_q <= head_next;
    end
  end

  assign pc        = pc_q;
  assign next_pc   = pc_q + 16'd1;
  assign out_instr = head_q.instr;
  assign out_imm   = head_q.imm;
  assign out_len   = head_q.len;
  assign out_pc    = head_q.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit with a behavioural word memory, a
// program-order scoreboard and directed checks around reset, stall,
// redirect, address wraparound and asynchronous reset.
module tb_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [15:0] pc;
  logic [15:0] next_pc;
  logic [15:0] fetch_instr;
  logic [15:0] fetch_next_instr;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_imm;
  logic        out_len;
  logic [15:0] out_pc;

  logic [15:0] mem [0:65535];
  assign fetch_instr      = mem[pc];
  assign fetch_next_instr = mem[next_pc];

  fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_en         (fetch_en),
    .pc               (pc),
    .next_pc          (next_pc),
    .fetch_instr      (fetch_instr),
    .fetch_next_instr (fetch_next_instr),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_imm          (out_imm),
    .out_len          (out_len),
    .out_pc           (out_pc)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry packing: {instr, imm, len, pc}
  logic [48:0] exp_q[$];

  // Walk the program in memory from start and queue the n instructions that
  // decode should see, in order.
  task automatic sb_load(input logic [15:0] start, input int n);
    logic [15:0] p;
    logic [15:0] w;
    logic [15:0] p1;
    p = start;
    for (int k = 0; k < n; k++) begin
      w  = mem[p];
      p1 = p + 16'd1;
      if (w[15]) begin
        exp_q.push_back({w, mem[p1], 1'b1, p});
        p = p + 16'd2;
      end else begin
        exp_q.push_back({w, 16'h0000, 1'b0, p});
        p = p1;
      end
    end
  endtask

  // Every completed transfer is compared against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_out", 64'(out_pc), 64'hFFFF_FFFF);
      end else begin
        check("head", 64'({out_instr, out_imm, out_len, out_pc}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7 + 3) & 16'h7FFF;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic en, input logic rdy);
    rst_n    = 1'b0;
    redirect = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", 64'(pc), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_out", 64'({out_instr, out_imm, out_len, out_pc}), 64'h0);
    fetch_en  = en;
    out_ready = rdy;
    rst_n     = 1'b1;
  endtask

  task automatic do_redirect(input logic [15:0] target, input int n);
    redirect    = 1'b1;
    redirect_pc = target;
    step();
    redirect = 1'b0;
    check("redir_valid", 64'(out_valid), 64'h0);
    check("redir_pc", 64'(pc), 64'(target));
    exp_q.delete();
    sb_load(target, n);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] held_pc;

  initial begin
    // A: basic one-word stream, latency and fetch_en=0
    fill_mem();
    mem[0] = 16'h1234;
    mem[1] = 16'h0042;
    apply_reset(1'b1, 1'b1);
    sb_load(16'h0000, 20);
    step();
    check("lat_valid", 64'(out_valid), 64'h1);
    check("lat_pc", 64'(out_pc), 64'h0);
    check("lat_instr", 64'(out_instr), 64'h1234);
    repeat (5) step();
    fetch_en = 1'b0;
    held_pc  = pc;
    repeat (3) step();
    check("en0_pc_hold", 64'(pc), 64'(held_pc));
    check("en0_drained", 64'(out_valid), 64'h0);

    // B: two-word instruction
    fill_mem();
    mem[0] = 16'h8005;
    mem[1] = 16'hABCD;
    mem[2] = 16'h0001;
    apply_reset(1'b1, 1'b1);
    sb_load(16'h0000, 10);
    step();
    check("two_pc", 64'(pc), 64'h2);
    check("two_len", 64'(out_len), 64'h1);
    check("two_imm", 64'(out_imm), 64'hABCD);
    repeat (4) step();

    // C: stall with a full queue, then release
    fill_mem();
    apply_reset(1'b1, 1'b0);
    sb_load(16'h0000, 30);
    for (int c = 0; c < 5; c++) begin
      step();
      check("stall_pc_out", 64'(out_pc), 64'h0);
      check("stall_instr", 64'(out_instr), 64'(mem[0]));
    end
    check("stall_pc", 64'(pc), 64'h2);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("no_gap", 64'(out_valid), 64'h1);
    end
    #4;

    // D: redirect while the queue holds two entries
    do_redirect(16'h0100, 10);
    step();
    check("redir_first_valid", 64'(out_valid), 64'h1);
    check("redir_first_pc", 64'(out_pc), 64'h0100);
    repeat (3) step();

    // E: address wraparound for two-word instructions
    mem[16'hFFFE] = 16'h8001;
    mem[16'hFFFF] = 16'h8000;
    mem[16'h0000] = 16'h5555;
    mem[16'h0001] = 16'h0007;
    do_redirect(16'hFFFE, 6);
    step();
    check("wrap_fffe_pc", 64'(pc), 64'h0);
    repeat (3) step();
    do_redirect(16'hFFFF, 6);
    step();
    check("wrap_ffff_pc", 64'(pc), 64'h1);
    check("wrap_ffff_len", 64'(out_len), 64'h1);
    check("wrap_ffff_imm", 64'(out_imm), 64'h5555);
    repeat (3) step();

    // F: asynchronous reset mid-cycle with the queue full
    out_ready = 1'b0;
    repeat (3) step();
    check("full_valid", 64'(out_valid), 64'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'h0);
    check("arst_pc", 64'(pc), 64'h0);
    check("arst_out", 64'({out_instr, out_imm, out_len, out_pc}), 64'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Drives the PC and PC+1 address buses into the unified 16-bit word memory and consumes the two combinational instruction words returned.
- Decodes instruction length: one word, or two words with the immediate in the next word.
- Pushes complete instructions into a small queue.
- Presents instructions to decode with a valid/ready handshake.
- Supports redirect (branch/jump) with a queue flush.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- DEPTH, 2, instruction queue entries (power of two, ≥2).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- fetch_en  input  1  permits fetch/push when high
- pc  output  16  fetch address to memory; equals the internal PC register
- next_pc  output  16  pc+1 modulo 2^16, combinational from pc
- fetch_instr  input  16  memory word at pc, combinational
- fetch_next_instr  input  16  memory word at next_pc, combinational
- redirect  input  1  flush and reload PC
- redirect_pc  input  16  new PC when redirect=1
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head
- out_instr  output  16  head instruction word
- out_imm  output  16  head immediate; 0 for one-word instructions
- out_len  output  1  0 = one word, 1 = two words
- out_pc  output  16  address of head instruction

Behaviour:
- Reset (rst_n=0, async):
  - pc = RESET_PC; queue count = 0.
  - out_valid = 0; out_instr, out_imm, out_len, out_pc = 0.
- Length decode: len = fetch_instr[15]. Two-word when 1.
- Entry formed each cycle: {instr=fetch_instr, imm=len ? fetch_next_instr : 16'h0000, len, pc}.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect & (count < DEPTH | pop).
  - Pushing when full with a simultaneous pop is legal. It gives full throughput of one instruction per cycle.
- On push: pc <= pc + (len ? 2 : 1), modulo 2^16, with 16-bit wraparound.
  - pc=FFFF, len=1: imm taken from address 0000; new pc = 0001.
  - pc=FFFE, len=1: new pc = 0000.
- No push: pc holds.
- Redirect, highest priority:
  - On the clock edge with redirect=1: count <= 0 and pc <= redirect_pc.
  - No push that cycle.
  - A pop in the same cycle is still a completed transfer; the entry is consumed, then discarded along with the rest.
  - out_valid is 0 the following cycle.
  - The first instruction from redirect_pc is valid one cycle later, provided fetch_en=1.
- Latency: an instruction fetched at edge N appears at out_* after edge N, i.e. it is visible in cycle N+1, when the queue was empty.
  - After rst_n deasserts with fetch_en=1, the first edge pushes the RESET_PC instruction; out_valid=1 after that edge.
- Queue is FIFO-ordered. out_* reflect the head, registered from queue storage. There is no combinational path from fetch_instr to out_*.
- out_* hold stable while out_valid=1 and out_ready=0.
- When count=0, out_* hold their last values; out_valid=0.
- Coherence: words are captured at push time. Memory writes to already-queued addresses are not reflected; software redirects after self-modifying stores.
- fetch_en=0: no push; pops continue; pc holds.
- Reset mid-operation: immediate return to the reset state. Any queued contents are lost.

Test Plan:
- Reset with RESET_PC=0000, mem[0]=1234, mem[1]=0042, fetch_en=1, out_ready=1 → first valid out: instr=1234, len=0, imm=0000, pc=0000. Next valid: pc=0001, instr=0042.
- mem[0]=8005, mem[1]=ABCD, mem[2]=0001 → out: instr=8005, len=1, imm=ABCD, pc=0000. Next: instr=0001, pc=0002.
- out_ready=0 for 5 cycles with one-word instructions → queue fills to DEPTH=2, pc stops advancing at 0002, out_* stable at the pc=0000 entry. Release → entries at 0000, 0001, 0002 delivered in order with no gaps.
- Redirect to 0100 while the queue holds 2 entries and out_ready=1 → next cycle out_valid=0, pc=0100; the following cycle out_pc=0100. No stale entries from before the redirect are ever observed.
- redirect_pc=FFFF, mem[FFFF]=8000, mem[0000]=5555 → out: imm=5555, len=1; pc becomes 0001.
- rst_n asserted asynchronously mid-cycle with the queue full → out_valid drops immediately, pc=RESET_PC before the next clock edge.
